ccff_loader: RTL and testbench
==============================

# ccff_loader

Configuration-chain loader feeding the `ccff_head` input of the first tile in a configuration-flip-flop chain (connection blocks, switch blocks, grid memories). It accepts the bitstream as bytes over a valid/ready stream, serializes it onto the chain with a per-bit shift enable for the `prog_clk` gate, and reports completion. It can optionally verify chain integrity by observing the chain's far-end `ccff_tail`.

## Interface
- `CHAIN_LEN`, default 32: number of configuration flip-flops in the chain; ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_LEN+9)`: width of the shift counter, derived from `CHAIN_LEN`; not overridden.

Ports:
- `prog_clk`  in  1: configuration clock.
- `prog_rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse that begins a load. Ignored while `busy`.
- `s_data`  in  8: bitstream byte, MSB shifted first.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: loader accepts `s_data` this cycle.
- `ccff_head`  out  1: serial data into the chain (registered).
- `ccff_shift_en`  out  1: the chain shifts on the next `prog_clk` edge (registered).
- `ccff_tail`  in  1: serial output of the last chain flip-flop.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: one-cycle pulse at the end of a load.
- `err`  out  1: sticky tail-check mismatch. Cleared by `start`.

## Operation
- States: IDLE, MARK, LOAD, FIN.
  - IDLE → MARK on `start` when `CCFF_TAIL_CHECK_EN` is defined; otherwise IDLE → LOAD.
- MARK: shifts the 8 bits of `CCFF_MARKER` = 8'hA5 onto the chain, MSB first, on 8 consecutive cycles. Needs no input. Then → LOAD.
- LOAD: shifts exactly `CHAIN_LEN` payload bits.
  - Consumes ceil(`CHAIN_LEN`/8) bytes.
  - In the final byte, only the top (`CHAIN_LEN` mod 8) bits are used when that remainder is nonzero. The low bits are discarded.
  - Byte buffer holds `bit_cnt` unshifted bits.
  - `s_ready` = LOAD && bytes_left > 0 && `bit_cnt` ≤ 1. A continuous stream therefore shifts every cycle with no bubble.
  - When `bit_cnt` = 0 and no byte arrives, `ccff_shift_en` = 0 and the chain holds.
- After the last payload shift → FIN. FIN pulses `done` for one cycle, then → IDLE.
- Final chain content: the last payload bit sits in the flip-flop nearest the head.
- Bytes offered outside LOAD, or beyond the required count, are not accepted (`s_ready` = 0).
- `start` while busy: ignored, with no effect on the counters.

## Timing
- Reset values: `s_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `err`=0, state IDLE. Reset takes effect immediately, mid-load included.
- A reset mid-load leaves the chain content undefined. Software must restart the load.
- `start` sampled at edge E0 → `busy`=1 after E0. The first `ccff_shift_en`=1 is presented after E1 and captured by the chain at E2.
- Total chain shifts: `CHAIN_LEN` without the check, `CHAIN_LEN`+8 with it.
- With a continuous stream and check enabled, `done` is high in the cycle after the final shift edge: E0 + `CHAIN_LEN` + 10 cycles.
- `busy` falls together with `done`.
- Tail sampling: on the edge of global shift k (1-based), the loader samples `ccff_tail` for k in `CHAIN_LEN`+1 … `CHAIN_LEN`+8. Each sample is compared with marker bit k−`CHAIN_LEN` (MSB first).

## Configuration
- `CCFF_TAIL_CHECK_EN` defined:
  - MARK state present.
  - Tail comparison active; any mismatch sets `err`, and `err` stays set through `done`.
  - `done` still pulses on a mismatch.
- `CCFF_TAIL_CHECK_EN` undefined:
  - No MARK state and no comparator.
  - `ccff_tail` unused; `err` tied to 0.
  - Exactly `CHAIN_LEN` shifts.

## Structure
- `ccff_loader_pkg` holds:
  - state enum `ccff_ld_state_t`
  - `CCFF_MARKER` = 8'hA5
  - `CCFF_MARKER_LEN` = 8
- Sub-module `ccff_loader_ser` is the byte buffer plus bit counter. It provides `s_ready`, the next bit and a bit-available flag. The top level holds the FSM, the global shift counter and the tail checker.

## Test plan
- `CHAIN_LEN`=20, check off, bytes 8'hC3, 8'h5A, 8'hF0 streamed continuously → 20 shifts. Chain model holds bitstream 1100_0011_0101_1010_1111, and the low nibble of 8'hF0 is never shifted. `done` arrives at E0+22.
- Same load with `s_valid` dropped for 5 cycles after the first byte → `ccff_shift_en` is low for exactly those cycles. Chain contents are identical, and `done` is delayed by 5 cycles.
- `CHAIN_LEN`=20, check on, correct 20-stage chain model → 28 shifts, `err`=0, `done` at E0+30.
- Check on, chain model with one stuck-at-0 stage → `err`=1 at `done` and stays set until the next `start`.
- Check on, chain model with 21 stages → marker misaligned, `err`=1.
- `prog_rst_n` asserted after 10 shifts → all outputs 0 immediately. A new `start` then completes a full, correct load.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared types and constants for the configuration-chain loader.
//               Holds the FSM state type, the tail-check marker and a helper
//               that gives the number of payload bits used from the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    CCFF_ST_IDLE = 2'd0,
    CCFF_ST_MARK = 2'd1,
    CCFF_ST_LOAD = 2'd2,
    CCFF_ST_FIN  = 2'd3
  } ccff_ld_state_t;

  // Pattern pushed ahead of the payload; it reappears at ccff_tail once the
  // payload has filled the chain, which proves the chain length and integrity.
  localparam logic [7:0] CCFF_MARKER     = 8'hA5;
  localparam int         CCFF_MARKER_LEN = 8;

  // Bits taken from the last byte of the bitstream (top bits, MSB first).
  function automatic int ccff_last_bits(input int chain_len);
    return ((chain_len % 8) == 0) ? 8 : (chain_len % 8);
  endfunction

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_loader_ser.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_ser
// Description : Byte buffer and bit counter of the chain loader. Accepts bytes
//               from the valid/ready stream, presents the next bit MSB first
//               and a bit-available flag. A byte arriving into an empty buffer
//               is bypassed so its first bit is available in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_loader_ser
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       load_en_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic       bit_o,
  output logic       bit_avail_o
);

  localparam int         NBYTES    = (CHAIN_LEN + 7) / 8;
  localparam logic [3:0] LAST_BITS = 4'(ccff_last_bits(CHAIN_LEN));

  logic [7:0]       byte_q, byte_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] bytes_left_q, bytes_left_d;
  logic             accept;
  logic [3:0]       nbits;

  // Refill is requested while the last buffered bit is still going out, so a
  // continuous stream never leaves a hole in the shift sequence.
  assign s_ready_o   = load_en_i && (bytes_left_q != '0) && (bit_cnt_q <= 4'd1);
  assign accept      = s_ready_o && s_valid_i;
  assign nbits       = (bytes_left_q == CNT_W'(1)) ? LAST_BITS : 4'd8;
  assign bit_avail_o = load_en_i && ((bit_cnt_q != 4'd0) || accept);
  assign bit_o       = (bit_cnt_q != 4'd0) ? byte_q[7] : s_data_i[7];

  // Next buffer state: restart, refill (bypass or append) or shift one bit.
  always_comb begin
    byte_d       = byte_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    if (clear_i) begin
      byte_d       = '0;
      bit_cnt_d    = '0;
      bytes_left_d = CNT_W'(NBYTES);
    end else if (accept) begin
      bytes_left_d = bytes_left_q - CNT_W'(1);
      if (bit_cnt_q == 4'd0) begin
        byte_d    = {s_data_i[6:0], 1'b0};
        bit_cnt_d = nbits - 4'd1;
      end else begin
        byte_d    = s_data_i;
        bit_cnt_d = nbits;
      end
    end else if (bit_avail_o) begin
      byte_d    = {byte_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 4'd1;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_q       <= '0;
      bit_cnt_q    <= '0;
      bytes_left_q <= '0;
    end else begin
      byte_q       <= byte_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
    end
  end

endmodule : ccff_loader_ser
`default_nettype wire

// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader
// Description : Configuration-chain loader. Serializes a byte stream onto
//               ccff_head with a per-bit shift enable and pulses done at the
//               end of a load. Build option CCFF_TAIL_CHECK_EN adds a marker
//               pre-load and a ccff_tail comparator driving a sticky err.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 9)
) (
  input  logic       prog_clk,
  input  logic       prog_rst_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] ST_IDLE = CCFF_ST_IDLE;
  localparam logic [1:0] ST_LOAD = CCFF_ST_LOAD;
  localparam logic [1:0] ST_FIN  = CCFF_ST_FIN;
`ifdef CCFF_TAIL_CHECK_EN
  localparam logic [1:0] ST_MARK      = CCFF_ST_MARK;
  localparam logic [1:0] ST_FIRST     = ST_MARK;
  localparam int         TOTAL_SHIFTS = CHAIN_LEN + CCFF_MARKER_LEN;
`else
  localparam logic [1:0] ST_FIRST     = ST_LOAD;
  localparam int         TOTAL_SHIFTS = CHAIN_LEN;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic             head_q, head_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_acc;
  logic             ser_bit, ser_avail;

  assign start_acc = start && (state_q == ST_IDLE) && !busy_q;

  ccff_loader_ser #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_ser (
    .clk_i       (prog_clk),
    .rst_ni      (prog_rst_n),
    .clear_i     (start_acc),
    .load_en_i   (state_q == ST_LOAD),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .bit_o       (ser_bit),
    .bit_avail_o (ser_avail)
  );

  // Sequencer: picks the bit for the next shift and steps through the load.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) state_d = ST_FIRST;
      end
`ifdef CCFF_TAIL_CHECK_EN
      ST_MARK: begin
        shift_en_d = 1'b1;
        head_d     = CCFF_MARKER[3'd7 - shift_cnt_q[2:0]];
        if (shift_cnt_q == CNT_W'(CCFF_MARKER_LEN - 1)) state_d = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        if (ser_avail) begin
          shift_en_d = 1'b1;
          head_d     = ser_bit;
          if (shift_cnt_q == CNT_W'(TOTAL_SHIFTS - 1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // shift_cnt counts shifts issued so far; it equals the 1-based index of
    // the shift the chain captures on the edge where shift_en_q is high.
    shift_cnt_d = start_acc ? '0 : (shift_cnt_q + CNT_W'(shift_en_d));
    done_d      = (state_q == ST_FIN);
    // busy stays up through the done cycle and drops with it.
    busy_d      = (state_d != ST_IDLE) || (state_q == ST_FIN);
  end

  // Control and chain-interface registers.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CCFF_TAIL_CHECK_EN
  logic       err_q, err_d;
  logic       tail_window;
  logic [2:0] mark_idx;

  // Shifts CHAIN_LEN+1..CHAIN_LEN+8 see the marker at the tail, MSB first.
  assign tail_window = shift_en_q && (shift_cnt_q > CNT_W'(CHAIN_LEN));
  assign mark_idx    = 3'(TOTAL_SHIFTS) - shift_cnt_q[2:0];

  // Sticky mismatch flag, cleared when a new load is accepted.
  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = 1'b0;
    end else if (tail_window && (ccff_tail != CCFF_MARKER[mark_idx])) begin
      err_d = 1'b1;
    end
  end

  // Error register.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) err_q <= 1'b0;
    else             err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule : ccff_loader
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_loader
// Description : Self-checking bench for ccff_loader (CHAIN_LEN = 20). A
//               behavioural chain model sits on ccff_head/ccff_tail; expected
//               chain content, shift totals and done latency are derived from
//               the bitstream and the stream gaps. Honours CCFF_TAIL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_loader;

  localparam int CL = 20;
  localparam int NB = (CL + 7) / 8;
`ifdef CCFF_TAIL_CHECK_EN
  localparam int TOTAL = CL + 8;
  localparam bit CHK   = 1'b1;
`else
  localparam int TOTAL = CL;
  localparam bit CHK   = 1'b0;
`endif

  logic       prog_clk = 1'b0;
  logic       prog_rst_n;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec  = 0;
  int n_miss = 0;

  // Chain model: bit 0 is the flip-flop next to the head.
  // mode 0: 20 good stages, mode 1: stage 7 stuck at 0, mode 2: 21 stages.
  logic [21:0] chain_m = '0;
  int          chain_mode = 0;
  int          hs_cnt = 0;
  int          sh_cnt = 0;

  ccff_loader #(.CHAIN_LEN(CL)) dut (
    .prog_clk      (prog_clk),
    .prog_rst_n    (prog_rst_n),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) begin
    if (ccff_shift_en)
      chain_m <= {chain_m[20:0], ccff_head} & ~((chain_mode == 1) ? 22'h80 : 22'h0);
    if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    if (ccff_shift_en)      sh_cnt <= sh_cnt + 1;
  end

  assign ccff_tail = (chain_mode == 2) ? chain_m[20] : chain_m[19];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One load. g1/g2: cycles s_valid is held low after the previous byte's
  // handshake. rst_after > 0 aborts the load with a reset after that many
  // captured shifts. Must be called right after a falling clock edge.
  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int g1, input int g2, input int mode,
                          input bit dup_start, input int rst_after);
    logic [7:0]      bytes [NB];
    int              gaps  [NB];
    logic [NB*8-1:0] stream;
    int d, stall, j, gap_left, hs0, sh0, n, done_n, idle, issued;
    bit first_seen, seen;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    gaps[0]  = 0;  gaps[1]  = g1; gaps[2]  = g2;
    stream   = {b0, b1, b2};

    // Expected stalls: the loader asks for a byte while its last buffered bit
    // goes out. A byte landing in an empty buffer yields 7 more bits before
    // the next request, otherwise 8. Every cycle the request stays unserved
    // past the buffer running dry costs one idle cycle.
    stall = 0;
    d     = 7;
    for (int k = 1; k < NB; k++) begin
      if (gaps[k] > d) stall += gaps[k] - d;
      d = (gaps[k] >= d) ? 7 : 8;
    end

    chain_mode = mode;
    hs0 = hs_cnt; sh0 = sh_cnt;
    s_data = bytes[0]; s_valid = 1'b1; start = 1'b1;
    j = 0; gap_left = 0; n = 0; done_n = -1; idle = 0; issued = 0;
    first_seen = 1'b0; seen = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("err_after_start", 32'(err), 32'd0);

    while (!seen && n < 300) begin
      if (hs_cnt - hs0 > j) begin
        j = hs_cnt - hs0;
        gap_left = (j < NB) ? gaps[j] : 0;
      end
      if (j >= NB) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
      end else if (gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end else begin
        s_valid = 1'b1;
        s_data  = bytes[j];
      end
      start = dup_start && (n == 4);
      if (ccff_shift_en) begin
        first_seen = 1'b1;
        issued++;
      end else if (first_seen && issued < TOTAL) begin
        idle++;
      end
      if (done) begin
        seen   = 1'b1;
        done_n = n;
      end
      if (rst_after > 0 && (sh_cnt - sh0) >= rst_after) begin
        prog_rst_n = 1'b0;
        #1;
        check_eq("reset_outputs",
                 32'({s_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
        s_valid = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge prog_clk);
        prog_rst_n = 1'b1;
        @(negedge prog_clk);
        return;
      end
      if (!seen) begin
        @(negedge prog_clk);
        n++;
      end
    end

    if (!seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("done_latency", 32'(done_n), 32'(TOTAL + 1 + stall));
      check_eq("shift_count", 32'(sh_cnt - sh0), 32'(TOTAL));
      check_eq("bytes_accepted", 32'(hs_cnt - hs0), 32'(NB));
      check_eq("idle_cycles", 32'(idle), 32'(stall));
      // The first payload bit travels furthest: chain[i] = stream bit 4+i.
      if (mode == 0) check_eq("chain_content", 32'(chain_m[CL-1:0]), 32'(stream[NB*8-1 -: CL]));
      check_eq("err_at_done", 32'(err), 32'(CHK && (mode != 0)));
    end
    s_valid = 1'b0;
    @(negedge prog_clk);
    check_eq("busy_done_fall", 32'({busy, done}), 32'd0);
    repeat (2) @(negedge prog_clk);
    check_eq("err_sticky", 32'(err), 32'(CHK && (mode != 0)));
  endtask

  initial begin
    prog_rst_n = 1'b0;
    start      = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    repeat (3) @(negedge prog_clk);
    check_eq("reset_state",
             32'({s_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);

    // Continuous stream, then a 5-cycle starvation after the first byte.
    run_load(8'hC3, 8'h5A, 8'hF0, 0, 0, 0, 1'b0, 0);
    run_load(8'hC3, 8'h5A, 8'hF0, 12, 0, 0, 1'b0, 0);
    // Faulty chains (err expected only when the tail check is built in),
    // then a good load that must clear err again.
    run_load(8'h96, 8'h3C, 8'h70, 0, 0, 1, 1'b0, 0);
    run_load(8'h12, 8'hEF, 8'hA0, 3, 9, 2, 1'b0, 0);
    run_load(8'hC3, 8'h5A, 8'hF0, 0, 0, 0, 1'b1, 0);
    // Reset after 10 shifts, then a full clean load.
    run_load(8'hFF, 8'hFF, 8'hF0, 0, 0, 0, 1'b0, 10);
    run_load(8'hC3, 8'h5A, 8'hF0, 0, 0, 0, 1'b0, 0);

    for (int r = 0; r < 10; r++) begin
      run_load(8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 14)),
               ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 14)),
               0, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_ccff_loader
`default_nettype wire
